ifetch: RTL

Instruction fetch stage directly upstream of the instruction cache. It owns the program counter and drives the cache read port. The cache returns data combinationally, so the fetched word is captured in the same cycle. A 2-entry instruction buffer decouples fetch from decode back-pressure. Branch/jump redirects from execute, and a halt on the all-zero word, are handled here.

---
 rtl/ifetch_if.sv | 29 ++
 rtl/ifetch.sv | 93 +++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: cache read port, redirect from execute and the
// instruction buffer head presented to decode.
//   master : the fetch stage (drives o_*, samples i_*)
//   slave  : the surrounding cache / execute / decode environment
interface ifetch_if #(
  parameter int unsigned WIDTH = 32
);
  logic             o_mem_rq;       // fetch request to the cache
  logic             o_rnw;          // read-not-write, always 1
  logic [WIDTH-1:0] o_pc;           // fetch address
  logic [WIDTH-1:0] i_inst;         // cache read data, same cycle
  logic             i_redirect;     // branch/jump taken
  logic [WIDTH-1:0] i_redirect_pc;  // redirect target
  logic             i_ready;        // decode accepts head entry
  logic             o_valid;        // head entry valid
  logic [WIDTH-1:0] o_inst;         // head instruction
  logic [WIDTH-1:0] o_inst_pc;      // head instruction PC
  logic             o_halted;       // fetch stopped on zero word

  modport master (
    output o_mem_rq, o_rnw, o_pc, o_valid, o_inst, o_inst_pc, o_halted,
    input  i_inst, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_mem_rq, o_rnw, o_pc, o_valid, o_inst, o_inst_pc, o_halted,
    output i_inst, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage. Owns the PC, issues combinational reads to the
// instruction cache and queues fetched words in a 2-entry buffer for decode.
// Redirects flush the buffer and reload the PC; an all-zero word halts fetch.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : ifetch_if master (cache port, redirect, decode handshake)
module ifetch #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic      i_clk,
  input logic      i_reset,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [1:0]       count_q, count_d, count_mid;
  logic [WIDTH-1:0] inst_q [2];
  logic [WIDTH-1:0] inst_d [2];
  logic [WIDTH-1:0] ipc_q  [2];
  logic [WIDTH-1:0] ipc_d  [2];
  logic             fetch, push, pop, valid;

  assign valid = (count_q != 2'd0) & ~bus.i_redirect;
  assign pop   = valid & bus.i_ready;
  // A full buffer may still fetch when the head leaves this cycle.
  assign fetch = (state_q == StRun) & ~bus.i_redirect & ((count_q < 2'd2) | pop);
  assign push  = fetch & (bus.i_inst != '0);

  assign bus.o_rnw     = 1'b1;
  assign bus.o_pc      = pc_q;
  assign bus.o_mem_rq  = fetch;
  assign bus.o_valid   = valid;
  assign bus.o_inst    = inst_q[0];
  assign bus.o_inst_pc = ipc_q[0];
  assign bus.o_halted  = (state_q == StHalted);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    count_mid = count_q;
    inst_d    = inst_q;
    ipc_d     = ipc_q;
    if (bus.i_redirect) begin
      count_d = 2'd0;
      // Mask keeps the target word aligned; low bits are simply discarded.
      pc_d    = bus.i_redirect_pc & ~WIDTH'(3);
      state_d = StRun;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StRun;
        StRun:    if (fetch && !push) state_d = StHalted;
        default:  state_d = state_q;
      endcase
      // Entry 0 is always the head: pop shifts, push writes the first free slot.
      if (pop) begin
        inst_d[0] = inst_q[1];
        ipc_d[0]  = ipc_q[1];
        count_mid = count_q - 2'd1;
      end
      if (push) begin
        inst_d[count_mid[0]] = bus.i_inst;
        ipc_d[count_mid[0]]  = pc_q;
        pc_d                 = pc_q + WIDTH'(4);
        count_d              = count_mid + 2'd1;
      end else begin
        count_d = count_mid;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      inst_q  <= '{default: '0};
      ipc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule
